dbus_mem_responder: RTL and testbench



---
 rtl/dbus_mem_responder.sv | 153 +++++++++++++++
 tb/tb_dbus_mem_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_mem_responder.sv
// Fixed-latency 64-bit data-bus memory responder with byte strobes, range/alignment
// checking, a saturating error counter and a sticky hold-rule violation flag.
package dbus_pkg;
    localparam logic [1:0] DSIZE_1B = 2'd0;
    localparam logic [1:0] DSIZE_2B = 2'd1;
    localparam logic [1:0] DSIZE_4B = 2'd2;
    localparam logic [1:0] DSIZE_8B = 2'd3;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [1:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module dbus_mem_responder
    import dbus_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  dbus_req_t   dreq,
    output dbus_resp_t  dresp,
    output logic [15:0] err_cnt,
    output logic        proto_viol
);
    localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [63:0] SPAN_BYTES = 64'(DEPTH_WORDS) << 3;
    localparam logic [3:0]  LAT        = LATENCY[3:0];

    typedef enum logic [1:0] { IDLE, WAIT, RESP } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [15:0]      errCnt_q, errCnt_d;
    logic             viol_q, viol_d;
    logic [63:0]      addr_q, data_q;
    logic [7:0]       strobe_q;
    logic [IDX_W-1:0] idx_q;
    logic             bad_q;
    logic             accept, commit;
    logic [63:0]      offset;
    logic [2:0]       alignMask;
    logic             reqBad, holdBroken;
    logic [63:0]      mem_q [DEPTH_WORDS];

    // Unsigned offset arithmetic: addresses below the base wrap to huge offsets.
    always_comb begin
        offset     = dreq.addr - BASE_ADDR;
        alignMask  = 3'((4'd1 << dreq.size) - 4'd1);
        reqBad     = (offset >= SPAN_BYTES) || ((dreq.addr[2:0] & alignMask) != 3'b000);
        holdBroken = !dreq.valid || (dreq.addr != addr_q) || (dreq.strobe != strobe_q);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        errCnt_d = errCnt_q;
        viol_d   = viol_q;
        accept   = 1'b0;
        commit   = 1'b0;
        dresp    = '0;
        unique case (state_q)
            IDLE: begin
                if (dreq.valid) begin
                    accept  = 1'b1;
                    cnt_d   = LAT;
                    state_d = (LAT == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (holdBroken) begin
                    viol_d  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                cnt_d   = 4'd0;
                state_d = IDLE;
                if (holdBroken) begin
                    viol_d = 1'b1;
                end else begin
                    commit        = 1'b1;
                    dresp.addr_ok = 1'b1;
                    dresp.data_ok = 1'b1;
                    dresp.data    = bad_q ? 64'd0 : mem_q[idx_q];
                    if (bad_q && (errCnt_q != 16'hFFFF)) begin
                        errCnt_d = errCnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            errCnt_q <= 16'd0;
            viol_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            errCnt_q <= errCnt_d;
            viol_q   <= viol_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q   <= dreq.addr;
            strobe_q <= dreq.strobe;
            data_q   <= dreq.data;
            idx_q    <= offset[3 +: IDX_W];
            bad_q    <= reqBad;
        end
    end

    // Backing store is never reset; a reset in the RESP cycle still cancels the write.
    always_ff @(posedge clk) begin
        if (!reset && commit && !bad_q) begin
            for (int b = 0; b < 8; b++) begin
                if (strobe_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= data_q[8*b +: 8];
                end
            end
        end
    end

    assign err_cnt    = errCnt_q;
    assign proto_viol = viol_q;
endmodule

// File: tb/tb_dbus_mem_responder.sv
// Bench for dbus_mem_responder: four instances with latencies 0, 2, 3 and 4 checked
// every cycle against a transaction-level model, plus hand-computed expectations.
module tb_dbus_mem_responder;
    import dbus_pkg::*;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int unsigned DEPTH = 1024;
    localparam int          NDUT  = 4;

    logic        clk = 1'b0;
    logic        reset;
    dbus_req_t   dreqArr  [NDUT];
    dbus_resp_t  drespArr [NDUT];
    logic [15:0] errArr   [NDUT];
    logic        violArr  [NDUT];

    int          cycle = 0;
    int          expRespCycle [NDUT];
    logic [63:0] expData      [NDUT];
    bit          expKnown     [NDUT];
    logic [63:0] modelMem     [NDUT][16];
    bit          known        [NDUT][16];
    logic [15:0] modelErr     [NDUT];
    logic        modelViol    [NDUT];
    int          okCount      [NDUT];
    int          lastOkCycle  [NDUT];
    int          issueCycle   [NDUT];
    logic [63:0] lastData     [NDUT];
    bit          checkEn = 1'b0;
    int          totalChecks = 0;
    int          badChecks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        dbus_mem_responder #(
            .DEPTH_WORDS(DEPTH),
            .LATENCY((g == 0) ? 0 : g + 1),
            .BASE_ADDR(BASE)
        ) uDut (
            .clk(clk),
            .reset(reset),
            .dreq(dreqArr[g]),
            .dresp(drespArr[g]),
            .err_cnt(errArr[g]),
            .proto_viol(violArr[g])
        );
    end

    task automatic checkOutput(input string name, input int k, input logic [63:0] act,
                               input logic [63:0] exp);
        totalChecks++;
        if (act !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s dut%0d cycle=%0d got=%h want=%h", name, k, cycle, act, exp);
        end
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            for (int k = 0; k < NDUT; k++) begin
                if (cycle == expRespCycle[k]) begin
                    checkOutput("addr_ok", k, 64'(drespArr[k].addr_ok), 64'd1);
                    checkOutput("data_ok", k, 64'(drespArr[k].data_ok), 64'd1);
                    if (expKnown[k]) checkOutput("rdata", k, drespArr[k].data, expData[k]);
                end else begin
                    checkOutput("addr_ok_quiet", k, 64'(drespArr[k].addr_ok), 64'd0);
                    checkOutput("data_ok_quiet", k, 64'(drespArr[k].data_ok), 64'd0);
                    checkOutput("data_quiet", k, drespArr[k].data, 64'd0);
                end
                checkOutput("err_cnt", k, 64'(errArr[k]), 64'(modelErr[k]));
                checkOutput("proto_viol", k, 64'(violArr[k]), 64'(modelViol[k]));
                if (drespArr[k].data_ok === 1'b1) begin
                    okCount[k]++;
                    lastOkCycle[k] = cycle;
                    lastData[k]    = drespArr[k].data;
                end
            end
        end
    end

    // One complete transaction on instance k; dropEarly releases valid right after acceptance.
    task automatic applyStimulus(input int k, input logic [63:0] addr, input logic [1:0] size,
                                 input logic [7:0] strobe, input logic [63:0] data,
                                 input bit dropEarly);
        int          c0;
        int          lat;
        int          w;
        logic [63:0] off;
        bit          isBad;
        c0    = cycle;
        lat   = (k == 0) ? 0 : k + 1;
        off   = addr - BASE;
        isBad = (off >= 64'(DEPTH) * 64'd8) || ((addr % (64'd1 << size)) != 64'd0);
        w     = int'(off >> 3) & 15;
        dreqArr[k]      = '{valid: 1'b1, addr: addr, size: size, strobe: strobe, data: data};
        issueCycle[k]   = c0;
        okCount[k]      = 0;
        expRespCycle[k] = c0 + 1 + lat;
        expKnown[k]     = isBad ? 1'b1 : known[k][w];
        expData[k]      = isBad ? 64'd0 : modelMem[k][w];
        if (dropEarly) begin
            waitCycle();
            dreqArr[k].valid = 1'b0;
            expRespCycle[k]  = -1;
            waitCycle();
            modelViol[k] = 1'b1;
        end else begin
            while (cycle < c0 + 2 + lat) waitCycle();
            if (isBad) begin
                if (modelErr[k] != 16'hFFFF) modelErr[k] = modelErr[k] + 16'd1;
            end else begin
                for (int b = 0; b < 8; b++) begin
                    if (strobe[b]) modelMem[k][w][8*b +: 8] = data[8*b +: 8];
                end
                if (strobe == 8'hFF) known[k][w] = 1'b1;
            end
            dreqArr[k].valid = 1'b0;
        end
    endtask

    task automatic applyReset();
        reset = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            dreqArr[k].valid = 1'b0;
            expRespCycle[k]  = -1;
        end
        waitCycle();
        reset = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            modelErr[k]  = 16'd0;
            modelViol[k] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog cycle=%0d got=timeout want=finish", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        reset = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            dreqArr[k]      = '0;
            expRespCycle[k] = -1;
            expKnown[k]     = 1'b0;
            expData[k]      = 64'd0;
            modelErr[k]     = 16'd0;
            modelViol[k]    = 1'b0;
            okCount[k]      = 0;
            lastOkCycle[k]  = 0;
            issueCycle[k]   = 0;
            lastData[k]     = 64'd0;
            for (int w = 0; w < 16; w++) begin
                modelMem[k][w] = 64'd0;
                known[k][w]    = 1'b0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        reset   = 1'b0;
        checkEn = 1'b1;

        // Latency 0: first request issued in the very cycle reset drops.
        applyStimulus(0, BASE, DSIZE_8B, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0);
        applyStimulus(0, BASE, DSIZE_8B, 8'h00, 64'd0, 1'b0);
        checkOutput("lat0_delay", 0, 64'(lastOkCycle[0] - issueCycle[0]), 64'd1);
        checkOutput("lat0_width", 0, 64'(okCount[0]), 64'd1);
        checkOutput("lat0_data", 0, lastData[0], 64'h0123_4567_89AB_CDEF);

        // Latency 2 read.
        applyStimulus(1, BASE, DSIZE_8B, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0);
        applyStimulus(1, BASE, DSIZE_8B, 8'h00, 64'd0, 1'b0);
        checkOutput("lat2_delay", 1, 64'(lastOkCycle[1] - issueCycle[1]), 64'd3);
        checkOutput("lat2_width", 1, 64'(okCount[1]), 64'd1);

        // Byte-strobe merge.
        applyStimulus(1, BASE + 64'd8, DSIZE_8B, 8'hFF, 64'h1122_3344_5566_7788, 1'b0);
        applyStimulus(1, BASE + 64'd8, DSIZE_8B, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 1'b0);
        checkOutput("strobe_prewrite", 1, lastData[1], 64'h1122_3344_5566_7788);
        applyStimulus(1, BASE + 64'd8, DSIZE_8B, 8'h00, 64'd0, 1'b0);
        checkOutput("strobe_merge", 1, lastData[1], 64'h1122_3344_BBBB_BBBB);

        // Back-to-back write then read of the same word.
        applyStimulus(1, BASE + 64'd16, DSIZE_8B, 8'hFF, 64'hDEAD, 1'b0);
        applyStimulus(1, BASE + 64'd16, DSIZE_8B, 8'h00, 64'd0, 1'b0);
        checkOutput("b2b_data", 1, lastData[1], 64'hDEAD);
        checkOutput("b2b_delay", 1, 64'(lastOkCycle[1] - issueCycle[1]), 64'd3);

        // Below-base, past-end and misaligned requests.
        applyStimulus(1, BASE - 64'd8, DSIZE_8B, 8'h00, 64'd0, 1'b0);
        checkOutput("err_below_data", 1, lastData[1], 64'd0);
        applyStimulus(1, BASE + 64'(DEPTH) * 64'd8, DSIZE_8B, 8'h00, 64'd0, 1'b0);
        checkOutput("err_above_data", 1, lastData[1], 64'd0);
        applyStimulus(1, BASE + 64'd2, DSIZE_4B, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        checkOutput("err_misalign_data", 1, lastData[1], 64'd0);
        checkOutput("err_count3", 1, 64'(errArr[1]), 64'd3);
        applyStimulus(1, BASE, DSIZE_8B, 8'h00, 64'd0, 1'b0);
        checkOutput("err_no_write", 1, lastData[1], 64'h0123_4567_89AB_CDEF);

        // Hold-rule violation on latency 3.
        applyStimulus(2, BASE + 64'd32, DSIZE_8B, 8'hFF, 64'hCAFE, 1'b0);
        applyStimulus(2, BASE + 64'd32, DSIZE_8B, 8'hFF, 64'hBAD, 1'b1);
        repeat (4) waitCycle();
        checkOutput("viol_set", 2, 64'(violArr[2]), 64'd1);
        checkOutput("viol_no_ok", 2, 64'(okCount[2]), 64'd0);
        applyStimulus(2, BASE + 64'd32, DSIZE_8B, 8'h00, 64'd0, 1'b0);
        checkOutput("viol_word_kept", 2, lastData[2], 64'hCAFE);
        applyReset();
        checkOutput("viol_cleared", 2, 64'(violArr[2]), 64'd0);

        // Reset pulsed while latency 4 write is waiting.
        applyStimulus(3, BASE + 64'd24, DSIZE_8B, 8'hFF, 64'h5555_6666_7777_8888, 1'b0);
        c0 = cycle;
        dreqArr[3] = '{valid: 1'b1, addr: BASE + 64'd24, size: DSIZE_8B, strobe: 8'hFF,
                       data: 64'hFFFF_0000_FFFF_0000};
        okCount[3]      = 0;
        expRespCycle[3] = c0 + 5;
        expKnown[3]     = 1'b1;
        expData[3]      = modelMem[3][3];
        waitCycle();
        waitCycle();
        applyReset();
        repeat (6) waitCycle();
        checkOutput("rst_no_ok", 3, 64'(okCount[3]), 64'd0);
        checkOutput("rst_err_zero", 3, 64'(errArr[3]), 64'd0);
        applyStimulus(3, BASE + 64'd24, DSIZE_8B, 8'h00, 64'd0, 1'b0);
        checkOutput("rst_word_kept", 3, lastData[3], 64'h5555_6666_7777_8888);
        checkOutput("rst_next_delay", 3, 64'(lastOkCycle[3] - issueCycle[3]), 64'd5);

        repeat (2) waitCycle();
        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end
endmodule
